// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: decodes IR opcode/funct and sequences datapath/memory strobes.
// Outputs mostly decoded from state; FETCH/MEMRD/MEMWR stall on mem_ready when USE_MEM_READY is set.
module mips_multicycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     cur, nxt;
  logic       ready;
  logic       funct_ok;
  logic       illegal_set;
  logic [2:0] funct_alu;

  assign ready = USE_MEM_READY ? mem_ready : 1'b1;
  assign state = cur;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'd0;
    case (funct)
      6'b100000: funct_alu = 3'd0;
      6'b100010: funct_alu = 3'd1;
      6'b100100: funct_alu = 3'd2;
      6'b100101: funct_alu = 3'd3;
      6'b101010: funct_alu = 3'd4;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= S_IDLE;
      illegal_op <= 1'b0;
    end else begin
      cur <= nxt;
      if (illegal_set) illegal_op <= 1'b1;
    end
  end

  always_comb begin
    nxt         = S_IDLE;
    illegal_set = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_ctrl    = 3'd0;
    pc_src      = 2'b00;
    pc_en       = 1'b0;
    case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready;
        pc_en     = ready;
        nxt       = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          OP_R: begin
            nxt         = funct_ok ? S_EXEC : S_FETCH;
            illegal_set = !funct_ok;
          end
          default: begin
            nxt         = S_FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        nxt      = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        nxt       = ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu;
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_ctrl  = funct_alu;
        nxt       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = 3'd1;
        pc_src    = 2'b01;
        pc_en     = zero;
        nxt       = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        nxt       = S_FETCH;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
        nxt    = S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction expected state/input sequences checked every cycle.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic       pc_en, illegal_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src), .pc_en(pc_en),
    .illegal_op(illegal_op), .state(state)
  );

  typedef struct packed {
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       pc_en, illegal_op;
    logic [3:0] state;
  } out_t;

  typedef struct {
    int st;
    bit mr;
    bit z;
    bit ill;
  } rec_t;

  out_t act;
  assign act = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_ctrl, pc_src, pc_en, illegal_op, state};

  rec_t q[$];
  out_t olog[$];
  bit   ill_m = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [5:0] ops[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                         6'b001000, 6'b000010, 6'b111111, 6'b010001};
  logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic logic [2:0] fn_alu(logic [5:0] fn);
    for (int i = 0; i < 5; i++) if (fns[i] == fn) return 3'(i);
    return 3'd0;
  endfunction

  // Expected outputs for one cycle, from the per-state output table.
  function automatic out_t expect_out(int st, bit mr, bit z, bit ill, logic [5:0] fn);
    out_t o;
    o = '0;
    o.state = 4'(st);
    o.illegal_op = ill;
    case (st)
      1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
      2:  o.alu_src_b = 2'b11;
      3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4:  begin o.iord = 1; o.mem_read = 1; end
      5:  begin o.mem_to_reg = 1; o.reg_write = 1; end
      6:  begin o.iord = 1; o.mem_write = 1; end
      7:  begin o.alu_src_a = 1; o.alu_ctrl = fn_alu(fn); end
      8:  begin o.reg_dst = 1; o.reg_write = 1; o.alu_ctrl = fn_alu(fn); end
      9:  begin o.alu_src_a = 1; o.alu_ctrl = 3'd1; o.pc_src = 2'b01; o.pc_en = z; end
      10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      11: o.reg_write = 1;
      12: begin o.pc_src = 2'b10; o.pc_en = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(int st, bit mr, bit z);
    rec_t r;
    r.st = st; r.mr = mr; r.z = z; r.ill = ill_m;
    q.push_back(r);
  endtask

  // Expected cycle sequence of one instruction, with its mem_ready/zero stimulus.
  task automatic build(logic [5:0] op, logic [5:0] fn, bit z, int wf, int wm);
    repeat (wf) push(1, 1'b0, rb());
    push(1, 1'b1, rb());
    push(2, rb(), rb());
    case (op)
      6'b100011: begin
        push(3, rb(), rb());
        repeat (wm) push(4, 1'b0, rb());
        push(4, 1'b1, rb());
        push(5, rb(), rb());
      end
      6'b101011: begin
        push(3, rb(), rb());
        repeat (wm) push(6, 1'b0, rb());
        push(6, 1'b1, rb());
      end
      6'b000000: begin
        if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
          push(7, rb(), rb());
          push(8, rb(), rb());
        end else ill_m = 1'b1;
      end
      6'b000100: push(9, rb(), z);
      6'b001000: begin push(10, rb(), rb()); push(11, rb(), rb()); end
      6'b000010: push(12, rb(), rb());
      default:   ill_m = 1'b1;
    endcase
  endtask

  task automatic check_out(string name, out_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h (state act=%0d req=%0d)",
               name, $time, act, e, act.state, e.state);
    end
  endtask

  task automatic chk(string name, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, a, e);
    end
  endtask

  task automatic run_n(int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = q.pop_front();
      mem_ready = r.mr;
      zero = r.z;
      @(negedge clk);
      olog.push_back(act);
      check_out("cycle", expect_out(r.st, r.mr, r.z, r.ill, funct));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit z, int wf, int wm);
    opcode = op;
    funct = fn;
    build(op, fn, z, wf, wm);
    run_n(q.size());
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    mem_ready = 1'b0;
    ill_m = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check_out("reset", expect_out(0, 1'b0, 1'b0, 1'b0, 6'd0));
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lw_states[8] = '{1, 2, 3, 4, 4, 4, 5, 1};
    do_reset(2);

    // lw with mem_ready low for two cycles in MEMRD, plus a stalled first fetch pinned below
    olog.delete();
    run_instr(6'b100011, 6'd0, 1'b0, 0, 2);
    run_instr(6'b000010, 6'd0, 1'b0, 1, 0);
    for (int i = 0; i < 8; i++) chk("lw_state_seq", int'(olog[i].state), lw_states[i]);
    chk("lw_regwrite_memwb", int'(olog[6].reg_write), 1);
    chk("fetch_stall_pc_en", int'(olog[7].pc_en), 0);

    olog.delete();
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
    chk("sub_exec_alu", int'(olog[2].alu_ctrl), 1);
    chk("sub_aluwb_alu", int'(olog[3].alu_ctrl), 1);
    chk("sub_aluwb_regdst", int'(olog[3].reg_dst), 1);

    olog.delete();
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
    chk("slt_exec_alu", int'(olog[2].alu_ctrl), 4);

    olog.delete();
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0);
    chk("beq_taken_pc_en", int'(olog[2].pc_en), 1);
    chk("beq_taken_pc_src", int'(olog[2].pc_src), 1);

    olog.delete();
    run_instr(6'b000100, 6'd0, 1'b0, 0, 0);
    chk("beq_not_taken_pc_en", int'(olog[2].pc_en), 0);
    chk("beq_not_taken_state", int'(olog[2].state), 9);

    olog.delete();
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    chk("illegal_before_decode", int'(olog[1].illegal_op), 0);
    olog.delete();
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0);
    chk("illegal_sticky_fetch", int'(olog[0].illegal_op), 1);
    run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 7)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // reset while a store is stalled in MEMWR
    opcode = 6'b101011;
    funct = 6'd0;
    build(6'b101011, 6'd0, 1'b0, 0, 3);
    run_n(4);
    q.delete();
    do_reset(1);

    for (int n = 0; n < 15; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 7)];
      run_instr(op, fns[$urandom_range(0, 4)], rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
